// File: rtl/regfile_sb.sv
// regfile_sb: 2R/1W register file with write-to-read bypass and pending-write scoreboard
module regfile_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_REGS = 32,
    parameter int ZERO_REG = 1,
    parameter int CNT_W    = $clog2(NUM_REGS + 1)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_rd_en,
    input  logic [ADDR_W-1:0] i_rs1,
    input  logic [ADDR_W-1:0] i_rs2,
    output logic [DATA_W-1:0] o_rd1,
    output logic [DATA_W-1:0] o_rd2,
    output logic              o_rd1_pend,
    output logic              o_rd2_pend,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_ws,
    input  logic [DATA_W-1:0] i_wd,
    input  logic              i_sb_set,
    input  logic [ADDR_W-1:0] i_sb_addr,
    output logic [CNT_W-1:0]  o_pend_cnt
);
    logic [DATA_W-1:0]   r_regs [NUM_REGS];
    logic [NUM_REGS-1:0] r_sb;
    logic [NUM_REGS-1:0] w_sb_next;
    logic                w_wr_ok, w_set_ok, w_v1, w_v2, w_inc, w_dec;

    function automatic logic f_valid(input logic [ADDR_W-1:0] a);
        return (32'(a) < NUM_REGS) && !(ZERO_REG != 0 && a == '0);
    endfunction

    assign w_wr_ok  = i_wr_en && f_valid(i_ws);
    assign w_set_ok = i_sb_set && f_valid(i_sb_addr);
    assign w_v1     = f_valid(i_rs1);
    assign w_v2     = f_valid(i_rs2);

    // Scoreboard after this edge: a write retires its entry, a same-cycle set re-arms it
    always_comb begin
        w_sb_next = r_sb;
        if (w_wr_ok) w_sb_next[i_ws] = 1'b0;
        if (w_set_ok) w_sb_next[i_sb_addr] = 1'b1;
    end

    assign w_inc = w_set_ok && !r_sb[i_sb_addr];
    assign w_dec = w_wr_ok && r_sb[i_ws] && !(w_set_ok && i_sb_addr == i_ws);

    // Register array, scoreboard, pending counter and registered read ports
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
            r_sb       <= '0;
            o_pend_cnt <= '0;
            o_rd1      <= '0;
            o_rd2      <= '0;
            o_rd1_pend <= 1'b0;
            o_rd2_pend <= 1'b0;
        end else begin
            if (w_wr_ok) r_regs[i_ws] <= i_wd;
            r_sb       <= w_sb_next;
            o_pend_cnt <= o_pend_cnt + CNT_W'(w_inc) - CNT_W'(w_dec);
            if (i_rd_en) begin
                o_rd1      <= !w_v1 ? '0 : (w_wr_ok && i_ws == i_rs1) ? i_wd : r_regs[i_rs1];
                o_rd2      <= !w_v2 ? '0 : (w_wr_ok && i_ws == i_rs2) ? i_wd : r_regs[i_rs2];
                o_rd1_pend <= w_v1 ? w_sb_next[i_rs1] : 1'b0;
                o_rd2_pend <= w_v2 ? w_sb_next[i_rs2] : 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed and random checks of regfile_sb against a behavioural model
module tb_regfile_sb;
    localparam int NR = 24;

    logic        clk = 1'b0;
    logic        rst_n, rd_en, wr_en, sb_set;
    logic [4:0]  rs1, rs2, ws, sb_addr;
    logic [31:0] wd, rd1, rd2;
    logic        rd1_pend, rd2_pend;
    logic [4:0]  pend_cnt;

    logic [31:0] m_reg [32];
    logic        m_sb  [32];
    logic [31:0] e_rd1, e_rd2;
    logic        e_p1, e_p2;
    int          e_cnt;
    int          checks = 0, passes = 0;

    regfile_sb #(.DATA_W(32), .ADDR_W(5), .NUM_REGS(NR), .ZERO_REG(1)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_rd_en(rd_en), .i_rs1(rs1), .i_rs2(rs2),
        .o_rd1(rd1), .o_rd2(rd2), .o_rd1_pend(rd1_pend), .o_rd2_pend(rd2_pend),
        .i_wr_en(wr_en), .i_ws(ws), .i_wd(wd), .i_sb_set(sb_set), .i_sb_addr(sb_addr),
        .o_pend_cnt(pend_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic ok(input logic [4:0] a);
        return int'(a) < NR && a != 0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) passes++;
        else $error("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    // Apply one cycle of inputs, advance the model, then compare every output
    task automatic cyc(input logic rn, input logic re, input logic [4:0] a1, input logic [4:0] a2,
                       input logic we, input logic [4:0] w, input logic [31:0] d,
                       input logic se, input logic [4:0] sa);
        rst_n = rn; rd_en = re; rs1 = a1; rs2 = a2;
        wr_en = we; ws = w; wd = d; sb_set = se; sb_addr = sa;
        if (!rn) begin
            for (int i = 0; i < 32; i++) begin m_reg[i] = 0; m_sb[i] = 0; end
            e_rd1 = 0; e_rd2 = 0; e_p1 = 0; e_p2 = 0;
        end else begin
            if (we && ok(w)) begin m_reg[w] = d; m_sb[w] = 0; end
            if (se && ok(sa)) m_sb[sa] = 1;
            if (re) begin
                e_rd1 = ok(a1) ? m_reg[a1] : 0;
                e_rd2 = ok(a2) ? m_reg[a2] : 0;
                e_p1  = ok(a1) ? m_sb[a1] : 0;
                e_p2  = ok(a2) ? m_sb[a2] : 0;
            end
        end
        e_cnt = 0;
        for (int i = 0; i < 32; i++) e_cnt += int'(m_sb[i]);
        @(posedge clk);
        #1;
        chk("rd1", rd1, e_rd1);
        chk("rd2", rd2, e_rd2);
        chk("rd1_pend", 32'(rd1_pend), 32'(e_p1));
        chk("rd2_pend", 32'(rd2_pend), 32'(e_p2));
        chk("pend_cnt", 32'(pend_cnt), 32'(e_cnt));
    endtask

    initial begin
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
        // T1: preload, then reset with a concurrent write
        cyc(1, 0, 0, 0, 1, 1, 32'h11, 1, 2);
        cyc(1, 0, 0, 0, 1, 4, 32'h44, 0, 0);
        cyc(0, 1, 4, 1, 1, 4, 32'h55, 1, 6);
        chk("t1_rd1_rst", rd1, 0);
        cyc(1, 1, 4, 1, 0, 0, 0, 0, 0);
        chk("t1_rd1", rd1, 0);
        chk("t1_rd2", rd2, 0);
        chk("t1_cnt", 32'(pend_cnt), 0);
        // T2: write then read
        cyc(1, 0, 0, 0, 1, 5, 32'hDEADBEEF, 0, 0);
        cyc(1, 1, 5, 4, 0, 0, 0, 0, 0);
        chk("t2_rd1", rd1, 32'hDEADBEEF);
        chk("t2_rd2", rd2, 0);
        // T3: bypass
        cyc(1, 1, 7, 7, 1, 7, 32'h1234, 0, 0);
        chk("t3_rd1", rd1, 32'h1234);
        chk("t3_rd2", rd2, 32'h1234);
        chk("t3_p1", 32'(rd1_pend), 0);
        // T4: zero register
        cyc(1, 1, 0, 0, 1, 0, 32'hFFFFFFFF, 1, 0);
        chk("t4_rd1", rd1, 0);
        chk("t4_cnt", 32'(pend_cnt), 0);
        cyc(1, 1, 0, 5, 0, 0, 0, 0, 0);
        chk("t4_rd1b", rd1, 0);
        // T5: scoreboard
        cyc(1, 0, 0, 0, 0, 0, 0, 1, 3);
        cyc(1, 0, 0, 0, 0, 0, 0, 1, 9);
        chk("t5_cnt2", 32'(pend_cnt), 2);
        cyc(1, 1, 3, 9, 0, 0, 0, 0, 0);
        chk("t5_p1", 32'(rd1_pend), 1);
        cyc(1, 1, 3, 3, 1, 3, 32'hA5, 1, 3);
        chk("t5_cnt_same", 32'(pend_cnt), 2);
        chk("t5_p1_same", 32'(rd1_pend), 1);
        chk("t5_bypass", rd1, 32'hA5);
        cyc(1, 1, 9, 3, 1, 9, 32'h99, 0, 0);
        chk("t5_cnt1", 32'(pend_cnt), 1);
        chk("t5_p1_clr", 32'(rd1_pend), 0);
        chk("t5_p2", 32'(rd2_pend), 1);
        // T6: out-of-range and hold
        cyc(1, 0, 0, 0, 1, 30, 32'hBAD, 1, 30);
        cyc(1, 1, 30, 23, 0, 0, 0, 0, 0);
        chk("t6_rd1", rd1, 0);
        chk("t6_cnt", 32'(pend_cnt), 1);
        cyc(1, 1, 5, 5, 0, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            cyc(1, 0, 5, 5, 1, 5, 32'hC0DE0000 + 32'(k), 1, 5);
            chk("t6_hold", rd1, 32'hDEADBEEF);
            chk("t6_hold_p", 32'(rd1_pend), 0);
        end
        cyc(1, 1, 5, 6, 0, 0, 0, 0, 0);
        chk("t6_after", rd1, 32'hC0DE0002);
        // Random traffic against the model
        for (int n = 0; n < 600; n++)
            cyc(($urandom_range(0, 59) != 0), 1'($urandom), 5'($urandom), 5'($urandom),
                1'($urandom), 5'($urandom), $urandom, ($urandom_range(0, 2) != 0), 5'($urandom));
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
